// File: rtl/alu_pkg.sv
// Shared ALU definitions.
// Purpose: operation encoding and sequencer state type, used by seq_alu,
//          alu_single_cycle and the ALU controller that drives alu_operation.
// Contents:
//   alu_op_t     - 4-bit operation code
//   alu_state_t  - seq_alu FSM state
//   is_shift_op  - true for the multi-cycle shift operations
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_LEU = 4'd5,
    ALU_LES = 4'd6,
    ALU_GEU = 4'd7,
    ALU_GES = 4'd8,
    ALU_LTU = 4'd9,
    ALU_LTS = 4'd10,
    ALU_GTU = 4'd11,
    ALU_GTS = 4'd12,
    ALU_SLL = 4'd13,
    ALU_SRL = 4'd14,
    ALU_SRA = 4'd15
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_t;

  function automatic logic is_shift_op(input alu_op_t op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_single_cycle.sv
// Single-cycle ALU core: arithmetic, logic and compare operations.
// Purpose: purely combinational evaluation of every non-shift operation.
//          For shift opcodes it passes operand a through, which is the
//          correct answer for a zero shift amount; non-zero shifts are
//          carried out bit-serially by seq_alu.
// Ports:
//   op  - operation code
//   a   - first operand
//   b   - second operand
//   y   - result (compares give 1 for true, 0 for false)
module alu_single_cycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_LEU: y[0] = (a <= b);
      ALU_LES: y[0] = ($signed(a) <= $signed(b));
      ALU_GEU: y[0] = (a >= b);
      ALU_GES: y[0] = ($signed(a) >= $signed(b));
      ALU_LTU: y[0] = (a < b);
      ALU_LTS: y[0] = ($signed(a) < $signed(b));
      ALU_GTU: y[0] = (a > b);
      ALU_GTS: y[0] = ($signed(a) > $signed(b));
      ALU_SLL, ALU_SRL, ALU_SRA: y = a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with a bit-serial shifter.
// Purpose: accepts one operation at a time; non-shift operations (and
//          shifts by zero) complete in one cycle, shifts by n>0 take n+1
//          cycles, one bit per cycle.
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
//   a result transfers on a rising edge where out_valid && out_ready.
//   in_ready is high only in IDLE, out_valid only in DONE, so the block holds
//   a single operation and cannot accept and retire in the same cycle.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   in_valid/ready - request handshake
//   alu_operation  - operation code (alu_op_t encoding)
//   operand_a/b    - operands; operand_b[log2(WIDTH)-1:0] is the shift amount
//   out_valid/ready- result handshake
//   result, zero   - registered result and its ==0 flag
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_operation,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int SHW = $clog2(WIDTH);

  // FSM state is a named enum signal so checkers can bind to it directly.
  alu_state_t       state_q, state_d;
  alu_op_t          op_q, op_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [SHW-1:0]   count_q, count_d;

  alu_op_t          op_in;
  logic [SHW-1:0]   shamt_in;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] work_shifted;

  assign op_in    = alu_op_t'(alu_operation);
  assign shamt_in = operand_b[SHW-1:0];

  alu_single_cycle #(.WIDTH(WIDTH)) u_alu (
    .op (op_in),
    .a  (operand_a),
    .b  (operand_b),
    .y  (alu_y)
  );

  // One-bit step of the serial shifter, selected by the captured opcode.
  always_comb begin
    work_shifted = work_q;
    case (op_q)
      ALU_SLL: work_shifted = {work_q[WIDTH-2:0], 1'b0};
      ALU_SRL: work_shifted = {1'b0, work_q[WIDTH-1:1]};
      ALU_SRA: work_shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: work_shifted = work_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    result_d = result_q;
    count_d  = count_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d = op_in;
          if (is_shift_op(op_in) && (shamt_in != '0)) begin
            work_d  = operand_a;
            count_d = shamt_in;
            state_d = ST_SHIFT;
          end else begin
            result_d = alu_y;
            state_d  = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        // The last shift lands directly in result so DONE follows the
        // cycle in which the counter reaches zero (latency n+1).
        if (count_q == '0) begin
          result_d = work_q;
          state_d  = ST_DONE;
        end else begin
          work_d  = work_shifted;
          count_d = count_q - SHW'(1);
          if (count_q == SHW'(1)) begin
            result_d = work_shifted;
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= ALU_ADD;
      work_q   <= '0;
      result_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      result_q <= result_d;
      count_q  <= count_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = (result_q == '0);

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu: table of vectors plus hand-written multi-cycle
// sequences (stall in DONE, reset during SHIFT), scoreboard of expected
// results and latencies, single summary line at the end.
module tb_seq_alu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_operation;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  int          lat_q[$];

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_r;
    int          exp_lat;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs[NVEC];

  seq_alu #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .alu_operation (alu_operation),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .zero          (zero)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive one request; the expected result and latency go to the scoreboard.
  task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_r, input int exp_lat);
    @(negedge clk);
    check({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    exp_q.push_back(exp_r);
    lat_q.push_back(exp_lat);
    in_valid      = 1'b1;
    alu_operation = op;
    operand_a     = a;
    operand_b     = b;
    @(posedge clk);
    #1;
    // Scramble inputs after accept; the DUT must have captured them already.
    in_valid      = 1'b0;
    alu_operation = 4'($urandom_range(0, 15));
    operand_a     = $urandom;
    operand_b     = $urandom;
  endtask

  // Wait for out_valid (latency counted from the accept edge), compare against
  // the scoreboard, and optionally retire the result.
  task automatic collect(input string name, input bit release_it);
    int          lat;
    bit          got;
    logic [31:0] exp_r;
    int          exp_lat;
    lat = 1;
    got = 1'b0;
    while (lat <= 100) begin
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    exp_r   = exp_q.pop_front();
    exp_lat = lat_q.pop_front();
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got no out_valid, expected it after %0d cycles", name, exp_lat);
      return;
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_result"}, result, exp_r);
    check({name, "_zero"}, {31'd0, zero}, {31'd0, (exp_r == 32'd0)});
    if (release_it) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({name, "_idle_after"}, {30'd0, in_ready, out_valid}, 32'b10);
    end
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r, input int exp_lat);
    issue(name, op, a, b, exp_r, exp_lat);
    collect(name, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] ra, rb;
    bit          stale;

    vecs[0]  = '{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1};
    vecs[1]  = '{4'd1,  32'h00001234, 32'h00001234, 32'h00000000, 1};
    vecs[2]  = '{4'd10, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1};
    vecs[3]  = '{4'd9,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1};
    vecs[4]  = '{4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1};
    vecs[5]  = '{4'd3,  32'h0F0F0000, 32'h000000FF, 32'h0F0F00FF, 1};
    vecs[6]  = '{4'd4,  32'hA5A5A5A5, 32'hFFFFFFFF, 32'h5A5A5A5A, 1};
    vecs[7]  = '{4'd5,  32'h00000005, 32'h00000005, 32'h00000001, 1};
    vecs[8]  = '{4'd6,  32'h80000000, 32'h00000000, 32'h00000001, 1};
    vecs[9]  = '{4'd7,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1};
    vecs[10] = '{4'd8,  32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1};
    vecs[11] = '{4'd11, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1};
    vecs[12] = '{4'd12, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1};
    vecs[13] = '{4'd1,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1};
    vecs[14] = '{4'd15, 32'h80000000, 32'd31,       32'hFFFFFFFF, 32};
    vecs[15] = '{4'd14, 32'h80000000, 32'd31,       32'h00000001, 32};
    vecs[16] = '{4'd13, 32'h00000001, 32'd4,        32'h00000010, 5};
    vecs[17] = '{4'd13, 32'h12345678, 32'h00000020, 32'h12345678, 1};
    vecs[18] = '{4'd15, 32'h7FFFFFF0, 32'd4,        32'h07FFFFFF, 5};
    vecs[19] = '{4'd14, 32'hF0000000, 32'd1,        32'h78000000, 2};
    vecs[20] = '{4'd15, 32'hF0000000, 32'd1,        32'hF8000000, 2};
    vecs[21] = '{4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1};

    rst           = 1'b1;
    in_valid      = 1'b0;
    out_ready     = 1'b0;
    alu_operation = 4'd0;
    operand_a     = 32'd0;
    operand_b     = 32'd0;

    // Reset state
    #3;
    check("reset_in_ready",  {31'd0, in_ready},  32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_result",    result,             32'd0);
    check("reset_zero",      {31'd0, zero},      32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < NVEC; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp_r, vecs[i].exp_lat);
    end

    // Random arithmetic/logic vectors with a bench-side model
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      case (i % 3)
        0: run_op($sformatf("rnd_add%0d", i), 4'd0, ra, rb, ra + rb, 1);
        1: run_op($sformatf("rnd_sub%0d", i), 4'd1, ra, rb, ra - rb, 1);
        default: run_op($sformatf("rnd_xor%0d", i), 4'd4, ra, rb, ra ^ rb, 1);
      endcase
    end

    // Stall in DONE for 5 cycles with a competing request on the input
    issue("stall", 4'd0, 32'd3, 32'd4, 32'd7, 1);
    collect("stall", 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid      = 1'b1;
      alu_operation = 4'd1;
      operand_a     = 32'd100;
      operand_b     = 32'd1;
      @(posedge clk);
      #1;
      check($sformatf("stall_result%0d", k), result, 32'd7);
      check($sformatf("stall_hs%0d", k), {30'd0, in_ready, out_valid}, 32'b01);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("stall_release", {30'd0, in_ready, out_valid}, 32'b10);
    stale = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) stale = 1'b1;
    end
    check("stall_ignored_req", {31'd0, stale}, 32'd0);
    run_op("after_stall", 4'd2, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 1);

    // Reset during SHIFT: SLL by 20, reset when the counter holds 10
    @(negedge clk);
    in_valid      = 1'b1;
    alu_operation = 4'd13;
    operand_a     = 32'h00000001;
    operand_b     = 32'd20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_in_ready",  {31'd0, in_ready},  32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_result",    result,             32'd0);
    check("midrst_zero",      {31'd0, zero},      32'd1);
    @(negedge clk);
    rst = 1'b0;
    stale = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (out_valid || !in_ready) stale = 1'b1;
    end
    check("midrst_no_stale", {31'd0, stale}, 32'd0);
    run_op("after_rst", 4'd14, 32'h00000100, 32'd3, 32'h00000020, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
